pipeline_elastic_reg: RTL
=========================

// Module: pipeline_elastic_reg
// PURPOSE
//   Parametrised elastic pipeline register chain with full valid/ready handshake.
//   Next generation of the plain valid/hold stage register: multi-stage depth,
//   back-pressure via ready, registered (non-combinational) upstream ready via
//   per-stage skid entry, pipeline flush, global hold and occupancy count.
//   Sits between rvcpu pipeline stages (IF->ID, ID->EX, LSU queues).
// PARAMETERS
//   WIDTH  32  payload width in bits (>=1)
//   DEPTH  1   number of elastic stages in chain (1..8)
//   CW     $clog2(2*DEPTH+1)  occupancy counter width (localparam, not overridable)
// PORTS
//   clk       in   1      clock, all state updates on posedge
//   rst       in   1      synchronous reset, active-high
//   flush_i   in   1      synchronous clear of every stage (pipeline flush)
//   hold_i    in   1      freeze: no transfer accepted or delivered this cycle
//   data_i    in   WIDTH  upstream payload
//   valid_i   in   1      upstream payload valid
//   ready_o   out  1      chain can accept data_i this cycle
//   data_o    out  WIDTH  downstream payload, all-zero when valid_o=0
//   valid_o   out  1      downstream payload valid
//   ready_i   in   1      downstream accepts data_o
//   count_o   out  CW     number of payloads held in chain (0..2*DEPTH)
// BEHAVIOUR
//   Reset (rst=1 at posedge): all stages EMPTY, count_o=0, data_o=0, valid_o=0;
//     ready_o=1 once hold_i=0 (stage-0 ready flop resets to 1).
//   Each stage k has a main entry, a skid entry and a 3-state FSM:
//     EMPTY: push -> HALF.
//     HALF : push&pop -> HALF (main<=in); push only -> FULL (skid<=in);
//            pop only -> EMPTY.
//     FULL : pop -> HALF (main<=skid); push is impossible (ready=0).
//   Stage upstream ready = registered (state_next != FULL); no comb path from
//     ready_i to ready_o.
//   push_k = valid_in_k & ready_k; pop_k = main_valid_k & ready_out_k.
//   Stage 0 input = data_i/valid_i; stage DEPTH-1 output drives data_o/valid_o.
//   hold_i=1: ready_o=0, valid_o=0, data_o=0, no stage moves; state, count_o
//     unchanged; ready_i and valid_i ignored. Combinational gating only.
//   flush_i=1 (rst=0): all stages EMPTY, skid/main data zeroed, count_o=0 next
//     cycle; any handshake in the flush cycle is discarded (flush beats push
//     and pop; flush beats hold). rst has priority over flush_i.
//   Latency: empty chain, ready_i=1, no hold: data_i accepted at cycle N
//     appears on data_o with valid_o=1 at cycle N+DEPTH.
//   Throughput: 1 payload/cycle sustained when ready_i=1.
//   Order: strict FIFO; no payload dropped or duplicated except by flush/rst.
//   Capacity: 2*DEPTH payloads; when count_o=2*DEPTH, ready_o=0 next cycle.
//   count_o: +1 on accepted input, -1 on delivered output, unchanged on both;
//     never wraps (saturation is an assertion failure, not a behaviour).
//   data_o is exactly {WIDTH{1'b0}} whenever valid_o=0 (no stale payload).
//   valid_o must not drop without a handshake except on hold_i, flush_i or rst.
//   rst/flush mid-transfer: payload in flight is lost, no partial output.
// TESTING
//   1 DEPTH=1, ready_i=1, push 0xA5A5A5A5 at cycle 3 -> valid_o=1, data_o=0xA5A5A5A5
//     at cycle 4, count_o 1 then 0.
//   2 DEPTH=3, ready_i=0, push 8 words 1..8 -> ready_o falls after 6 accepted,
//     count_o=6; raise ready_i -> data_o 1..6 on consecutive cycles.
//   3 DEPTH=2, stream 100 words, random ready_i toggling -> scoreboard in-order,
//     no loss/dup, ready_o never depends comb. on ready_i (check same-cycle).
//   4 DEPTH=2, 3 words held, hold_i=1 for 5 cycles -> valid_o=0, ready_o=0,
//     count_o=3 stable; release -> words resume in order.
//   5 DEPTH=4 full (count_o=8), flush_i=1 with valid_i=1 -> next cycle count_o=0,
//     valid_o=0, data_o=0, ready_o=1; pushed word never appears.
//   6 rst=1 mid-stream with hold_i=1 and flush_i=1 -> all outputs at reset values;
//     first push after rst released emerges after DEPTH cycles.

Source files
------------

// File: rtl/pipeline_elastic_reg_if.sv
// Upstream/downstream handshake bundle for the elastic pipeline register chain.
// Handshake: a word moves on a rising clock edge exactly when valid and ready
// are both high in that cycle. A producer holds valid and data stable until
// the transfer happens. ready_o is registered and never depends on ready_i
// within the same cycle. data_o is all-zero whenever valid_o is low.
interface pipeline_elastic_reg_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
);
  localparam int CW = $clog2(2 * DEPTH + 1);

  logic [WIDTH-1:0]   data_i;
  logic               valid_i;
  logic               ready_o;
  logic [WIDTH-1:0]   data_o;
  logic               valid_o;
  logic               ready_i;
  logic [CW-1:0]      count_o;
  logic [2*DEPTH-1:0] state_dbg;  // per-stage FSM state, stage k at [2k+1:2k]

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, count_o, state_dbg
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, count_o, state_dbg
  );
endinterface

// File: rtl/pipeline_elastic_reg.sv
// Elastic pipeline register chain: DEPTH stages, each with a main and a skid
// entry so upstream ready can be a flop. Supports flush, global hold and an
// occupancy count of payloads held in the chain.
module pipeline_elastic_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  hold_i,
  pipeline_elastic_reg_if.slave bus
);
  localparam int CW = $clog2(2 * DEPTH + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q [DEPTH];
  state_e           state_d [DEPTH];
  logic [WIDTH-1:0] main_q  [DEPTH];
  logic [WIDTH-1:0] main_d  [DEPTH];
  logic [WIDTH-1:0] skid_q  [DEPTH];
  logic [WIDTH-1:0] skid_d  [DEPTH];
  logic [WIDTH-1:0] in_data [DEPTH];
  logic [DEPTH-1:0] rdy_q;
  logic [DEPTH-1:0] rdy_d;
  logic [DEPTH-1:0] in_valid;
  logic [DEPTH-1:0] out_ready;
  logic [DEPTH-1:0] push;
  logic [DEPTH-1:0] pop;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             out_valid;

  // Per-stage handshake: hold_i freezes every transfer in the chain.
  always_comb begin
    in_valid[0] = bus.valid_i;
    in_data[0]  = bus.data_i;
    for (int k = 1; k < DEPTH; k++) begin
      in_valid[k] = (state_q[k-1] != S_EMPTY);
      in_data[k]  = main_q[k-1];
    end
    out_ready[DEPTH-1] = bus.ready_i;
    for (int k = 0; k < DEPTH - 1; k++) begin
      out_ready[k] = rdy_q[k+1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      push[k] = in_valid[k] & rdy_q[k] & ~hold_i;
      pop[k]  = (state_q[k] != S_EMPTY) & out_ready[k] & ~hold_i;
    end
  end

  // Stage FSM next state, entry data, registered ready and occupancy count.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      state_d[k] = state_q[k];
      main_d[k]  = main_q[k];
      skid_d[k]  = skid_q[k];
      unique case (state_q[k])
        S_EMPTY: begin
          if (push[k]) begin
            state_d[k] = S_HALF;
            main_d[k]  = in_data[k];
          end
        end
        S_HALF: begin
          if (push[k] && pop[k]) begin
            main_d[k] = in_data[k];
          end else if (push[k]) begin
            state_d[k] = S_FULL;
            skid_d[k]  = in_data[k];
          end else if (pop[k]) begin
            state_d[k] = S_EMPTY;
            main_d[k]  = '0;
          end
        end
        S_FULL: begin
          // ready is low here, so only a pop can happen
          if (pop[k]) begin
            state_d[k] = S_HALF;
            main_d[k]  = skid_q[k];
            skid_d[k]  = '0;
          end
        end
        default: begin
          state_d[k] = S_EMPTY;
        end
      endcase
      if (flush_i) begin
        state_d[k] = S_EMPTY;
        main_d[k]  = '0;
        skid_d[k]  = '0;
      end
      rdy_d[k] = (state_d[k] != S_FULL);
    end

    count_d = count_q;
    if (push[0] && !pop[DEPTH-1]) begin
      count_d = count_q + CW'(1);
    end else if (!push[0] && pop[DEPTH-1]) begin
      count_d = count_q - CW'(1);
    end
    if (flush_i) begin
      count_d = '0;
    end
  end

  // State registers; reset empties the chain and makes stage 0 ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        state_q[k] <= S_EMPTY;
        main_q[k]  <= '0;
        skid_q[k]  <= '0;
      end
      rdy_q   <= '1;
      count_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        state_q[k] <= state_d[k];
        main_q[k]  <= main_d[k];
        skid_q[k]  <= skid_d[k];
      end
      rdy_q   <= rdy_d;
      count_q <= count_d;
    end
  end

  // Outputs: hold masks the handshake combinationally, data is zero when idle.
  always_comb begin
    out_valid   = (state_q[DEPTH-1] != S_EMPTY) & ~hold_i;
    bus.valid_o = out_valid;
    bus.ready_o = rdy_q[0] & ~hold_i;
    bus.data_o  = out_valid ? main_q[DEPTH-1] : '0;
    bus.count_o = count_q;
    for (int k = 0; k < DEPTH; k++) begin
      bus.state_dbg[2*k +: 2] = state_q[k];
    end
  end

  // Occupancy can never exceed the chain capacity.
  count_le_cap: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(2 * DEPTH));
endmodule
